matrix_elementwise_unit: RTL and testbench

- Parametrised element-wise matrix ALU for the NPU datapath; next generation of the fixed 4x4 subtractor.
- Computes C = op(A, B) over a ROWS x COLS tile with a selectable mode: add, sub, reverse-sub or abs-diff.
- Supports signed or unsigned operands and LANES elements per cycle.
- Uses a start/busy/done handshake and sits between the operand tile buffers and the writeback stage.

---
 rtl/matrix_ew_pkg.sv | 39 +++
 rtl/matrix_ew_lane.sv | 63 ++++++
 rtl/matrix_elementwise_unit.sv | 136 +++++++++++++
 tb/tb_matrix_elementwise_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_ew_pkg.sv
// Shared types and the accumulate saturation helper for matrix_elementwise_unit.
// The helper is only referenced when MATRIX_EW_ACC_EN is defined.
package matrix_ew_pkg;

  typedef enum logic [1:0] {
    EW_ADD     = 2'b00,
    EW_SUB     = 2'b01,
    EW_RSUB    = 2'b10,
    EW_ABSDIFF = 2'b11
  } ew_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ew_state_e;

  localparam int EW_MAX_W = 64;

  // sum is a sign-extended two's complement value; clamp to the w-bit range.
  function automatic logic [EW_MAX_W-1:0] ew_sat(input logic [EW_MAX_W-1:0] sum,
                                                 input int unsigned w,
                                                 input logic is_signed);
    logic signed [EW_MAX_W-1:0] s;
    logic signed [EW_MAX_W-1:0] lo;
    logic signed [EW_MAX_W-1:0] hi;
    s  = $signed(sum);
    lo = is_signed ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    hi = is_signed ? ((64'sd1 <<< (w - 1)) - 64'sd1) : ((64'sd1 <<< w) - 64'sd1);
    if (s < lo) begin
      ew_sat = lo;
    end else if (s > hi) begin
      ew_sat = hi;
    end else begin
      ew_sat = s;
    end
  endfunction

endpackage

// File: rtl/matrix_ew_lane.sv
// Combinational per-element ALU: extend, add/sub/rsub/absdiff, and under
// MATRIX_EW_ACC_EN an optional saturating accumulate into the current c value.
module matrix_ew_lane
  import matrix_ew_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  b_i,
  input  logic [OUT_W-1:0] c_i,
  input  ew_mode_e         mode_i,
  input  logic             signed_i,
  input  logic             acc_i,
  output logic [OUT_W-1:0] res_o
);

  logic [OUT_W-1:0] a_x;
  logic [OUT_W-1:0] b_x;
  logic [OUT_W-1:0] op;
  logic             a_lt_b;

  always_comb begin
    a_x = signed_i ? {{(OUT_W-IN_W){a_i[IN_W-1]}}, a_i} : {{(OUT_W-IN_W){1'b0}}, a_i};
    b_x = signed_i ? {{(OUT_W-IN_W){b_i[IN_W-1]}}, b_i} : {{(OUT_W-IN_W){1'b0}}, b_i};
    a_lt_b = signed_i ? ($signed(a_x) < $signed(b_x)) : (a_x < b_x);
    op = '0;
    case (mode_i)
      EW_ADD:  op = a_x + b_x;
      EW_SUB:  op = a_x - b_x;
      EW_RSUB: op = b_x - a_x;
      default: op = a_lt_b ? (b_x - a_x) : (a_x - b_x);
    endcase
  end

`ifdef MATRIX_EW_ACC_EN
  // Two guard bits so an unsigned subtraction that drops below zero is still visible.
  localparam int XW = OUT_W + 2;

  logic [XW-1:0]       c_x;
  logic [XW-1:0]       op_x;
  logic [XW-1:0]       sum_x;
  logic                op_sext;
  logic [EW_MAX_W-1:0] sat_full;
  logic                unused_sat_hi;

  always_comb begin
    op_sext  = signed_i || (mode_i == EW_SUB) || (mode_i == EW_RSUB);
    c_x      = signed_i ? {{2{c_i[OUT_W-1]}}, c_i} : {2'b00, c_i};
    op_x     = op_sext ? {{2{op[OUT_W-1]}}, op} : {2'b00, op};
    sum_x    = c_x + op_x;
    sat_full = ew_sat({{(EW_MAX_W-XW){sum_x[XW-1]}}, sum_x}, OUT_W, signed_i);
    res_o    = acc_i ? sat_full[OUT_W-1:0] : op;
  end

  assign unused_sat_hi = ^sat_full[EW_MAX_W-1:OUT_W];
`else
  logic unused_acc;
  assign unused_acc = ^{c_i, acc_i};
  assign res_o      = op;
`endif

endmodule

// File: rtl/matrix_elementwise_unit.sv
// Element-wise matrix ALU over a ROWS x COLS tile, LANES elements per cycle,
// start/busy/done handshake. Optional accumulate mode: MATRIX_EW_ACC_EN.
module matrix_elementwise_unit
  import matrix_ew_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int LANES = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [1:0]                           mode,
  input  logic                                 signed_en,
  input  logic                                 acc_en,
  input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]  a,
  input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]  b,
  output logic [ROWS-1:0][COLS-1:0][OUT_W-1:0] c,
  output logic                                 busy,
  output logic                                 done,
  output ew_state_e                            state_dbg
);

  if ((LANES < 1) || (COLS % LANES != 0)) begin : g_bad_lanes
    $error("matrix_elementwise_unit: COLS must be a positive multiple of LANES");
  end
  if (OUT_W < IN_W + 1) begin : g_bad_width
    $error("matrix_elementwise_unit: OUT_W must be at least IN_W+1");
  end

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - LANES);

  ew_state_e                            state_q, state_d;
  logic [ROW_W-1:0]                     row_q, row_d;
  logic [COL_W-1:0]                     col_q, col_d;
  ew_mode_e                             mode_q, mode_d;
  logic                                 signed_q, signed_d;
  logic                                 acc_q, acc_d;
  logic [ROWS-1:0][COLS-1:0][OUT_W-1:0] c_q, c_d;
  logic [LANES-1:0][OUT_W-1:0]          lane_res;
  logic [LANES-1:0][COL_W-1:0]          lane_col;
  logic                                 last_grp;
  logic                                 capture;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_col[k] = col_q + COL_W'(k);
    matrix_ew_lane #(
      .IN_W (IN_W),
      .OUT_W(OUT_W)
    ) u_lane (
      .a_i     (a[row_q][lane_col[k]]),
      .b_i     (b[row_q][lane_col[k]]),
      .c_i     (c_q[row_q][lane_col[k]]),
      .mode_i  (mode_q),
      .signed_i(signed_q),
      .acc_i   (acc_q),
      .res_o   (lane_res[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    mode_d   = mode_q;
    signed_d = signed_q;
    acc_d    = acc_q;
    c_d      = c_q;
    busy     = 1'b0;
    done     = 1'b0;
    capture  = 1'b0;
    last_grp = (row_q == ROW_LAST) && (col_q == COL_LAST);
    case (state_q)
      IDLE: begin
        if (start) capture = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          c_d[row_q][lane_col[k]] = lane_res[k];
        end
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = last_grp ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(LANES);
        end
        if (last_grp) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A start seen during the done pulse chains straight into the next run.
        if (start) capture = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      state_d  = RUN;
      row_d    = '0;
      col_d    = '0;
      mode_d   = ew_mode_e'(mode);
      signed_d = signed_en;
      acc_d    = acc_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      mode_q   <= EW_ADD;
      signed_q <= 1'b0;
      acc_q    <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      mode_q   <= mode_d;
      signed_q <= signed_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
    end
  end

  assign c         = c_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_matrix_elementwise_unit.sv
// Scoreboard bench for matrix_elementwise_unit: a default instance (LANES=1, OUT_W=16)
// and a narrow instance (LANES=2, OUT_W=9) that also covers MATRIX_EW_ACC_EN.
module tb_matrix_elementwise_unit;
  import matrix_ew_pkg::*;

  localparam int W0 = 16 * 16;
  localparam int W1 = 16 * 9;

  typedef logic [3:0][3:0][15:0] tile0_t;
  typedef logic [3:0][3:0][8:0]  tile1_t;
  typedef logic [3:0][3:0][7:0]  opnd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       start0 = 1'b0, sen0 = 1'b0, acc0 = 1'b0;
  logic [1:0] mode0 = 2'b00;
  opnd_t      a0 = '0, b0 = '0;
  tile0_t     c0;
  logic       busy0, done0;
  ew_state_e  st0;

  logic       start1 = 1'b0, sen1 = 1'b0, acc1 = 1'b0;
  logic [1:0] mode1 = 2'b00;
  opnd_t      a1 = '0, b1 = '0;
  tile1_t     c1;
  logic       busy1, done1;
  ew_state_e  st1;

  matrix_elementwise_unit u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .signed_en(sen0), .acc_en(acc0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .state_dbg(st0)
  );

  matrix_elementwise_unit #(
    .ROWS(4), .COLS(4), .IN_W(8), .OUT_W(9), .LANES(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .signed_en(sen1), .acc_en(acc1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .state_dbg(st1)
  );

  // ---------------- scoreboard ----------------
  logic [W0-1:0] exp_q0[$];
  logic [W1-1:0] exp_q1[$];
  int tests_run = 0;
  int fails = 0;
  int done_cnt0 = 0, done_cnt1 = 0, tgt0 = 0, tgt1 = 0;
  int bcnt0 = 0, bcnt1 = 0, last_done0 = 0;
  logic prev_busy0 = 1'b0, prev_busy1 = 1'b0;

  task automatic check(input string name, input logic [W0-1:0] got, input logic [W0-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected tile and checks run length.
  always @(negedge clk) begin
    if (rst) begin
      bcnt0 = 0; bcnt1 = 0; prev_busy0 = 1'b0; prev_busy1 = 1'b0;
    end else begin
      if (busy0) bcnt0++;
      if (done0) begin
        done_cnt0++;
        last_done0 = cyc;
        check("dut0_busy_cycles", W0'(bcnt0), W0'(16));
        check("dut0_done_after_busy", W0'(prev_busy0), W0'(1));
        if (exp_q0.size() == 0) begin
          tests_run++; fails++;
          $display("FAIL dut0_tile: done with no queued expectation, got %0h", c0);
        end else begin
          check("dut0_tile", c0, exp_q0.pop_front());
        end
        bcnt0 = 0;
      end
      prev_busy0 = busy0;

      if (busy1) bcnt1++;
      if (done1) begin
        done_cnt1++;
        check("dut1_busy_cycles", W0'(bcnt1), W0'(8));
        check("dut1_done_after_busy", W0'(prev_busy1), W0'(1));
        if (exp_q1.size() == 0) begin
          tests_run++; fails++;
          $display("FAIL dut1_tile: done with no queued expectation, got %0h", c1);
        end else begin
          check("dut1_tile", W0'(c1), W0'(exp_q1.pop_front()));
        end
        bcnt1 = 0;
      end
      prev_busy1 = busy1;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic tile0_t fill0(input logic [15:0] v);
    tile0_t t;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) t[r][k] = v;
    return t;
  endfunction

  function automatic tile1_t fill1(input logic [8:0] v);
    tile1_t t;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) t[r][k] = v;
    return t;
  endfunction

  function automatic opnd_t fillop(input logic [7:0] v);
    opnd_t t;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) t[r][k] = v;
    return t;
  endfunction

  task automatic go0(input logic [1:0] m, input logic s, input tile0_t exp);
    @(posedge clk); #1;
    mode0 = m; sen0 = s; start0 = 1'b1;
    exp_q0.push_back(exp);
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic go1(input logic [1:0] m, input logic s, input logic ac, input tile1_t exp);
    @(posedge clk); #1;
    mode1 = m; sen1 = s; acc1 = ac; start1 = 1'b1;
    exp_q1.push_back(exp);
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done0();
    int t;
    t = 0;
    tgt0++;
    while (done_cnt0 < tgt0 && t < 100) begin @(negedge clk); #1; t++; end
    if (done_cnt0 < tgt0) begin
      tests_run++; fails++;
      $display("FAIL wait_done0: got %0d done pulses expected %0d", done_cnt0, tgt0);
    end
  endtask

  task automatic wait_done1();
    int t;
    t = 0;
    tgt1++;
    while (done_cnt1 < tgt1 && t < 100) begin @(negedge clk); #1; t++; end
    if (done_cnt1 < tgt1) begin
      tests_run++; fails++;
      $display("FAIL wait_done1: got %0d done pulses expected %0d", done_cnt1, tgt1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    tile0_t e0;
    tile1_t e1;
    int first_done;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_c0", c0, '0);
    check("reset_c1", W0'(c1), '0);
    check("reset_busy0", W0'(busy0), '0);
    check("reset_done0", W0'(done0), '0);
    check("reset_state0", W0'(st0), W0'(IDLE));
    rst = 1'b0;

    // Unsigned a-b: 200-50 = 150 everywhere.
    a0 = fillop(8'd200); b0 = fillop(8'd50);
    go0(2'b01, 1'b0, fill0(16'd150));
    wait_done0();

    // Signed |a-b| with -128 and 127 -> 255; other elements 0.
    a0 = '0; b0 = '0;
    a0[0][0] = 8'h80; b0[0][0] = 8'h7F;
    e0 = '0; e0[0][0] = 16'd255;
    go0(2'b11, 1'b1, e0);
    wait_done0();

    // Signed add of the same values -> -1.
    e0 = '0; e0[0][0] = 16'hFFFF;
    go0(2'b00, 1'b1, e0);
    wait_done0();

    // Unsigned b-a going negative: 5-250 = -245 = 16'hFF0B.
    a0 = fillop(8'd250); b0 = fillop(8'd5);
    go0(2'b10, 1'b0, fill0(16'hFF0B));
    wait_done0();

    // Reset in the middle of a run: everything clears at once.
    a0 = fillop(8'd3); b0 = fillop(8'd1);
    @(posedge clk); #1;
    mode0 = 2'b00; sen0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_c0", c0, '0);
    check("midrun_rst_busy0", W0'(busy0), '0);
    check("midrun_rst_done0", W0'(done0), '0);
    check("midrun_rst_state0", W0'(st0), W0'(IDLE));
    @(posedge clk); #2 rst = 1'b0;
    go0(2'b00, 1'b0, fill0(16'd4));
    wait_done0();

    // start held through DONE: back-to-back runs, done pulses 17 cycles apart.
    a0 = fillop(8'd10); b0 = fillop(8'd30);
    exp_q0.push_back(fill0(16'd20));
    exp_q0.push_back(fill0(16'd20));
    @(posedge clk); #1;
    mode0 = 2'b11; sen0 = 1'b0; start0 = 1'b1;
    wait_done0();
    first_done = last_done0;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done0();
    check("b2b_done_gap", W0'(last_done0 - first_done), W0'(17));

    // Narrow instance: signed add 127+127 twice with acc_en set.
    a1 = fillop(8'd127); b1 = fillop(8'd127);
    go1(2'b00, 1'b1, 1'b1, fill1(9'd254));
    wait_done1();
`ifdef MATRIX_EW_ACC_EN
    go1(2'b00, 1'b1, 1'b1, fill1(9'd255));
`else
    go1(2'b00, 1'b1, 1'b1, fill1(9'd254));
`endif
    wait_done1();

    // Two lanes, b-a with a[r][c]=r*4+c, b=20; a stray start mid-run is ignored.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        a1[r][k] = 8'(r * 4 + k);
        e1[r][k] = 9'(20 - (r * 4 + k));
      end
    end
    b1 = fillop(8'd20);
    go1(2'b10, 1'b0, 1'b0, e1);
    repeat (2) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done1();
    repeat (12) @(negedge clk);
    #1;
    check("stray_start_no_rerun", W0'(done_cnt1), W0'(tgt1));
    check("stray_start_idle_busy", W0'(busy1), '0);
    check("stray_start_idle_state", W0'(st1), W0'(IDLE));

    check("dut0_queue_drained", W0'(exp_q0.size()), '0);
    check("dut1_queue_drained", W0'(exp_q1.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
